// File: rtl/conv_sequencer.sv
// 1-D valid convolution sequencer: one time-shared DWxDW multiplier, one result
// per window position handed to the readout block over valid/ready.
module conv_sequencer #(
  parameter int DW      = 8,
  parameter int TAPS    = 4,
  parameter int SAMPLES = 16,
  parameter int ACCW    = 18
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [TAPS*DW-1:0]      weights,
  input  logic [SAMPLES*DW-1:0]   data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACCW-1:0]         out_data,
  output logic [3:0]              out_index,
  output logic                    busy,
  output logic                    done
);

  localparam int NOUT  = SAMPLES - TAPS + 1;
  localparam int TAPW  = $clog2(TAPS);
  localparam int SIDXW = $clog2(SAMPLES);

  typedef enum logic [1:0] {IDLE, MAC, EMIT, DONE} state_e;

  state_e            state_q, state_d;
  logic [ACCW-1:0]   acc_q, acc_d;
  logic [TAPW-1:0]   tap_q, tap_d;
  logic [3:0]        pos_q, pos_d;
  logic [ACCW-1:0]   outData_q, outData_d;
  logic [3:0]        outIndex_q, outIndex_d;
  logic              outValid_q, outValid_d;

  logic [DW-1:0]     samp_q [SAMPLES];
  logic [DW-1:0]     wt_q   [TAPS];

  logic              loadSnap;
  logic [SIDXW-1:0]  sampIdx;
  logic [2*DW-1:0]   prod;
  logic [ACCW-1:0]   accSum;

  assign sampIdx = SIDXW'(pos_q) + SIDXW'(tap_q);
  assign prod    = samp_q[sampIdx] * wt_q[tap_q];
  assign accSum  = (tap_q == '0) ? ACCW'(prod) : acc_q + ACCW'(prod);

  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_index = outIndex_q;
  assign busy      = (state_q == MAC) || (state_q == EMIT);
  assign done      = (state_q == DONE);

  // Operand snapshot: taken only when a run is accepted, so later SPI loads are invisible.
  always_ff @(posedge clk) begin
    if (loadSnap) begin
      for (int i = 0; i < SAMPLES; i++) samp_q[i] <= data[DW*i +: DW];
      for (int k = 0; k < TAPS; k++)    wt_q[k]   <= weights[DW*k +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      tap_q      <= '0;
      pos_q      <= '0;
      outData_q  <= '0;
      outIndex_q <= '0;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      tap_q      <= tap_d;
      pos_q      <= pos_d;
      outData_q  <= outData_d;
      outIndex_q <= outIndex_d;
      outValid_q <= outValid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    tap_d      = tap_q;
    pos_d      = pos_q;
    outData_d  = outData_q;
    outIndex_d = outIndex_q;
    outValid_d = outValid_q;
    loadSnap   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          loadSnap = 1'b1;
          pos_d    = '0;
          tap_d    = '0;
          state_d  = MAC;
        end
      end
      MAC: begin
        if (abort) begin
          outValid_d = 1'b0;
          state_d    = IDLE;
        end else begin
          acc_d = accSum;
          if (tap_q == TAPW'(TAPS - 1)) begin
            outData_d  = accSum;
            outIndex_d = pos_q;
            outValid_d = 1'b1;
            state_d    = EMIT;
          end else begin
            tap_d = tap_q + TAPW'(1);
          end
        end
      end
      EMIT: begin
        // Abort outranks a simultaneous handshake; that result is dropped.
        if (abort) begin
          outValid_d = 1'b0;
          state_d    = IDLE;
        end else if (outValid_q && out_ready) begin
          outValid_d = 1'b0;
          if (pos_q == 4'(NOUT - 1)) begin
            state_d = DONE;
          end else begin
            pos_d   = pos_q + 4'd1;
            tap_d   = '0;
            state_d = MAC;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
